// File: rtl/glip_downscale.sv
`default_nettype none
// ============================================================================
// Module  : glip_downscale
// Purpose : Splits one OUT_SIZE*RATIO-bit word into RATIO narrow beats,
//           most-significant slice first (GLIP_DOWNSCALE_LSB_FIRST_EN: LSB first).
// Revision: 1.0
// ============================================================================
module glip_downscale #(
  parameter int OUT_SIZE = 8,
  parameter int RATIO    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [OUT_SIZE*RATIO-1:0] in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [OUT_SIZE-1:0]       out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_last
);

  localparam int              IDX_W    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  typedef enum logic {
    EMPTY = 1'b0,
    EMIT  = 1'b1
  } state_t;

  state_t                           r_state;
  logic [IDX_W-1:0]                 r_idx;
  logic [RATIO-1:0][OUT_SIZE-1:0]   r_word;

  logic                             w_on_last;
  logic [IDX_W-1:0]                 w_sel;

  assign w_on_last = (r_state == EMIT) && (r_idx == LAST_IDX);
  assign out_valid = (r_state == EMIT);
  assign out_last  = w_on_last;
  // The next word loads on the same edge as the last beat, so no bubble.
  assign in_ready  = (r_state == EMPTY) || (out_ready && w_on_last);

`ifdef GLIP_DOWNSCALE_LSB_FIRST_EN
  assign w_sel = r_idx;
`else
  assign w_sel = LAST_IDX - r_idx;
`endif

  assign out_data = r_word[w_sel];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_idx   <= '0;
      r_word  <= '0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (in_valid) begin
            r_word  <= in_data;
            r_idx   <= '0;
            r_state <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (r_idx == LAST_IDX) begin
              r_idx <= '0;
              if (in_valid) begin
                r_word <= in_data;
              end else begin
                r_state <= EMPTY;
              end
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        default: begin
          r_state <= EMPTY;
          r_idx   <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_glip_downscale.sv
`default_nettype none
// ============================================================================
// Module  : tb_glip_downscale
// Purpose : Directed and randomized checks of glip_downscale (RATIO=2 and 4)
//           against a queue-based beat model. Honors GLIP_DOWNSCALE_LSB_FIRST_EN.
// Revision: 1.0
// ============================================================================
module tb_glip_downscale;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] in_data2;
  logic        in_valid2, in_ready2, out_valid2, out_ready2, out_last2;
  logic [7:0]  out_data2;

  logic [31:0] in_data4;
  logic        in_valid4, in_ready4, out_valid4, out_ready4, out_last4;
  logic [7:0]  out_data4;

  int n_asserts = 0;
  int n_fail    = 0;

  glip_downscale #(.OUT_SIZE(8), .RATIO(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
    .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready2),
    .out_last(out_last2)
  );

  glip_downscale #(.OUT_SIZE(8), .RATIO(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data4), .in_valid(in_valid4), .in_ready(in_ready4),
    .out_data(out_data4), .out_valid(out_valid4), .out_ready(out_ready4),
    .out_last(out_last4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Beat i of a word in emission order.
  function automatic logic [7:0] beat(input logic [31:0] word, input int ratio, input int i);
    int s;
`ifdef GLIP_DOWNSCALE_LSB_FIRST_EN
    s = i;
`else
    s = ratio - 1 - i;
`endif
    return 8'(word >> (8 * s));
  endfunction

  task automatic chk2(input string tag, input logic v, input logic [7:0] d,
                      input logic l, input logic r);
    chk({tag, "_valid"}, 32'(out_valid2), 32'(v));
    chk({tag, "_data"},  32'(out_data2),  32'(d));
    chk({tag, "_last"},  32'(out_last2),  32'(l));
    chk({tag, "_ready"}, 32'(in_ready2),  32'(r));
  endtask

  logic [31:0] words4 [3];
  logic [7:0]  q[$];
  int          acc;
  int          cyc;
  logic        exp_ready;

  initial begin
    in_data2 = '0; in_valid2 = 1'b0; out_ready2 = 1'b0;
    in_data4 = '0; in_valid4 = 1'b0; out_ready4 = 1'b0;
    words4[0] = 32'h11223344; words4[1] = 32'h55667788; words4[2] = 32'h99AABBCC;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk2("rst2", 1'b0, 8'h00, 1'b0, 1'b1);
    chk("rst4_valid", 32'(out_valid4), 32'd0);
    chk("rst4_data",  32'(out_data4),  32'd0);
    chk("rst4_ready", 32'(in_ready4),  32'd1);
    rst_n = 1'b1;

    // Single word, consumer always ready
    @(negedge clk);
    in_data2 = 16'hA5C3; in_valid2 = 1'b1; out_ready2 = 1'b1; #1;
    chk2("a_idle", 1'b0, 8'h00, 1'b0, 1'b1);
    @(negedge clk); in_valid2 = 1'b0; #1;
    chk2("a_b0", 1'b1, beat(32'hA5C3, 2, 0), 1'b0, 1'b0);
    @(negedge clk); #1;
    chk2("a_b1", 1'b1, beat(32'hA5C3, 2, 1), 1'b1, 1'b1);
    @(negedge clk); #1;
    chk("a_done_valid", 32'(out_valid2), 32'd0);
    chk("a_done_ready", 32'(in_ready2),  32'd1);

    // Backpressure on first and last slice
    in_data2 = 16'hBEEF; in_valid2 = 1'b1; out_ready2 = 1'b0;
    @(negedge clk); in_valid2 = 1'b0;
    repeat (5) begin
      #1 chk2("b_stall0", 1'b1, beat(32'hBEEF, 2, 0), 1'b0, 1'b0);
      @(negedge clk);
    end
    out_ready2 = 1'b1; #1;
    chk2("b_take0", 1'b1, beat(32'hBEEF, 2, 0), 1'b0, 1'b0);
    @(negedge clk);
    out_ready2 = 1'b0; in_valid2 = 1'b1; in_data2 = 16'h1357;
    repeat (2) begin
      #1 chk2("b_stall1", 1'b1, beat(32'hBEEF, 2, 1), 1'b1, 1'b0);
      @(negedge clk);
    end
    out_ready2 = 1'b1; #1;
    chk2("b_take1", 1'b1, beat(32'hBEEF, 2, 1), 1'b1, 1'b1);
    @(negedge clk); in_valid2 = 1'b0; #1;
    chk2("b_next0", 1'b1, beat(32'h1357, 2, 0), 1'b0, 1'b0);
    @(negedge clk); #1;
    chk2("b_next1", 1'b1, beat(32'h1357, 2, 1), 1'b1, 1'b1);
    @(negedge clk); #1;
    chk("b_done_valid", 32'(out_valid2), 32'd0);

    // Reset mid-word discards the remainder
    in_data2 = 16'h1234; in_valid2 = 1'b1;
    @(negedge clk); in_valid2 = 1'b0; #1;
    chk2("c_b0", 1'b1, beat(32'h1234, 2, 0), 1'b0, 1'b0);
    @(negedge clk);
    out_ready2 = 1'b0; rst_n = 1'b0; #1;
    chk2("c_rst", 1'b0, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1; in_data2 = 16'hCAFE; in_valid2 = 1'b1; out_ready2 = 1'b1;
    @(negedge clk); in_valid2 = 1'b0; #1;
    chk2("c_b0b", 1'b1, beat(32'hCAFE, 2, 0), 1'b0, 1'b0);
    @(negedge clk); #1;
    chk2("c_b1b", 1'b1, beat(32'hCAFE, 2, 1), 1'b1, 1'b1);
    @(negedge clk); #1;
    chk("c_done_valid", 32'(out_valid2), 32'd0);

    // RATIO=4, three back-to-back words, 12 contiguous beats
    out_ready4 = 1'b1;
    for (int k = 0; k <= 13; k++) begin
      in_valid4 = (k <= 8);
      in_data4  = (k == 0) ? words4[0] : words4[(k <= 8) ? (k + 3) / 4 : 2];
      #1;
      if (k >= 1 && k <= 12) begin
        chk("d_valid", 32'(out_valid4), 32'd1);
        chk("d_data",  32'(out_data4),  32'(beat(words4[(k - 1) / 4], 4, (k - 1) % 4)));
        chk("d_last",  32'(out_last4),  32'(((k - 1) % 4) == 3));
        chk("d_ready", 32'(in_ready4),  32'(((k - 1) % 4) == 3));
      end else begin
        chk("d_empty_valid", 32'(out_valid4), 32'd0);
        chk("d_empty_ready", 32'(in_ready4),  32'd1);
      end
      @(negedge clk);
    end
    in_valid4 = 1'b0;

    // Random valid/ready against a queue of outstanding beats
    acc = 0; cyc = 0;
    while (acc < 1000 && cyc < 20000) begin
      in_valid2  = ($urandom_range(0, 3) != 0);
      in_data2   = 16'($urandom);
      out_ready2 = ($urandom_range(0, 3) != 0);
      #1;
      exp_ready = (q.size() == 0) || (q.size() == 1 && out_ready2);
      chk("r_valid", 32'(out_valid2), 32'(q.size() > 0));
      chk("r_ready", 32'(in_ready2),  32'(exp_ready));
      if (q.size() > 0) begin
        chk("r_data", 32'(out_data2), 32'(q[0]));
        chk("r_last", 32'(out_last2), 32'(q.size() == 1));
        if (out_ready2) void'(q.pop_front());
      end
      if (in_valid2 && exp_ready) begin
        for (int i = 0; i < 2; i++) q.push_back(beat(32'(in_data2), 2, i));
        acc++;
      end
      cyc++;
      @(negedge clk);
    end
    chk("r_words", 32'(acc), 32'd1000);

    in_valid2 = 1'b0; out_ready2 = 1'b1;
    cyc = 0;
    while (q.size() > 0 && cyc < 10) begin
      #1;
      chk("r_drain_valid", 32'(out_valid2), 32'd1);
      chk("r_drain_data",  32'(out_data2),  32'(q[0]));
      void'(q.pop_front());
      cyc++;
      @(negedge clk);
    end
    #1;
    chk("r_drained", 32'(out_valid2), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
